id_ex_stage: RTL and testbench

Decode-to-execute pipeline stage sitting directly downstream of the 32×64 register file. Captures the two register-file read ports, resolves data hazards by forwarding from EX, MEM and WB, detects load-use hazards and stalls decode, and presents registered operands and control to the ALU. X31 is the zero register throughout: it is never a forwarding source or a hazard.

---
 rtl/cpu_pkg.sv | 20 ++
 rtl/fwd_unit.sv | 51 +++++
 rtl/id_ex_stage.sv | 110 +++++++++++
 tb/tb_id_ex_stage.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: zero-register index, forwarding source encoding and
// the producer/source match rule used by every bypass path.
package cpu_pkg;

    localparam logic [4:0] REG_ZERO = 5'd31;

    typedef enum logic [1:0] {FWD_RF, FWD_WB, FWD_MEM, FWD_EX} fwd_sel_t;

    // A producer only bypasses a real, register-writing result to a source that is actually read.
    function automatic logic producerHits(
        input logic       valid,
        input logic       regWrite,
        input logic [4:0] rd,
        input logic [4:0] src,
        input logic       usesSrc
    );
        return valid && regWrite && (rd == src) && (src != REG_ZERO) && usesSrc;
    endfunction

endpackage

// File: rtl/fwd_unit.sv
// Per-operand bypass: picks the youngest matching producer (EX > MEM > WB),
// falling back to the register-file read data.
module fwd_unit
    import cpu_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic [4:0]       src,
    input  logic             usesSrc,
    input  logic             exValid,
    input  logic             exRegWrite,
    input  logic             exMemRead,
    input  logic [4:0]       exRd,
    input  logic [WIDTH-1:0] exResult,
    input  logic             memValid,
    input  logic             memRegWrite,
    input  logic [4:0]       memRd,
    input  logic [WIDTH-1:0] memResult,
    input  logic             wbValid,
    input  logic             wbRegWrite,
    input  logic [4:0]       wbRd,
    input  logic [WIDTH-1:0] wbData,
    input  logic [WIDTH-1:0] rfData,
    output logic [WIDTH-1:0] operand
);

    fwd_sel_t sel;

    // Later assignments override earlier ones, so the youngest producer wins.
    // A load in EX has no data yet; that case is handled by the load-use stall.
    always_comb begin
        sel = FWD_RF;
        if (producerHits(wbValid, wbRegWrite, wbRd, src, usesSrc))
            sel = FWD_WB;
        if (producerHits(memValid, memRegWrite, memRd, src, usesSrc))
            sel = FWD_MEM;
        if (!exMemRead && producerHits(exValid, exRegWrite, exRd, src, usesSrc))
            sel = FWD_EX;
    end

    always_comb begin
        operand = rfData;
        case (sel)
            FWD_RF:  operand = rfData;
            FWD_WB:  operand = wbData;
            FWD_MEM: operand = memResult;
            FWD_EX:  operand = exResult;
        endcase
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand forwarding, load-use stall detection
// and a saturating count of stalled cycles.
module id_ex_stage
    import cpu_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int CTRLW = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             id_valid,
    input  logic [4:0]       id_Rn,
    input  logic [4:0]       id_Rm,
    input  logic             id_uses_Rn,
    input  logic             id_uses_Rm,
    input  logic [4:0]       id_Rd,
    input  logic             id_RegWrite,
    input  logic             id_MemRead,
    input  logic [CTRLW-1:0] id_ctrl,
    input  logic [WIDTH-1:0] ReadData1,
    input  logic [WIDTH-1:0] ReadData2,
    input  logic [WIDTH-1:0] ex_alu_result,
    input  logic             mem_valid,
    input  logic             mem_RegWrite,
    input  logic [4:0]       mem_Rd,
    input  logic [WIDTH-1:0] mem_result,
    input  logic             wb_valid,
    input  logic             wb_RegWrite,
    input  logic [4:0]       wb_Rd,
    input  logic [WIDTH-1:0] wb_data,
    input  logic             flush,
    output logic             stall_id,
    output logic             ex_valid,
    output logic             ex_RegWrite,
    output logic             ex_MemRead,
    output logic [4:0]       ex_Rd,
    output logic [WIDTH-1:0] ex_A,
    output logic [WIDTH-1:0] ex_B,
    output logic [CTRLW-1:0] ex_ctrl,
    output logic [31:0]      stall_cycles
);

    logic [WIDTH-1:0] fwdA;
    logic [WIDTH-1:0] fwdB;
    logic             loadUseHit;
    logic             bubble;
    logic [31:0]      stallCount;

    fwd_unit #(.WIDTH(WIDTH)) fwdRn (
        .src(id_Rn), .usesSrc(id_uses_Rn),
        .exValid(ex_valid), .exRegWrite(ex_RegWrite), .exMemRead(ex_MemRead),
        .exRd(ex_Rd), .exResult(ex_alu_result),
        .memValid(mem_valid), .memRegWrite(mem_RegWrite), .memRd(mem_Rd), .memResult(mem_result),
        .wbValid(wb_valid), .wbRegWrite(wb_RegWrite), .wbRd(wb_Rd), .wbData(wb_data),
        .rfData(ReadData1), .operand(fwdA)
    );

    fwd_unit #(.WIDTH(WIDTH)) fwdRm (
        .src(id_Rm), .usesSrc(id_uses_Rm),
        .exValid(ex_valid), .exRegWrite(ex_RegWrite), .exMemRead(ex_MemRead),
        .exRd(ex_Rd), .exResult(ex_alu_result),
        .memValid(mem_valid), .memRegWrite(mem_RegWrite), .memRd(mem_Rd), .memResult(mem_result),
        .wbValid(wb_valid), .wbRegWrite(wb_RegWrite), .wbRd(wb_Rd), .wbData(wb_data),
        .rfData(ReadData2), .operand(fwdB)
    );

    // Derived purely from registered EX state, so reset drops the stall immediately.
    assign loadUseHit = ex_valid && ex_MemRead && ex_RegWrite && (ex_Rd != REG_ZERO) &&
                        ((id_uses_Rn && (id_Rn == ex_Rd)) || (id_uses_Rm && (id_Rm == ex_Rd)));
    assign stall_id   = id_valid && loadUseHit && !flush;
    assign bubble     = flush || stall_id;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ex_valid    <= 1'b0;
            ex_RegWrite <= 1'b0;
            ex_MemRead  <= 1'b0;
            ex_Rd       <= REG_ZERO;
            ex_A        <= '0;
            ex_B        <= '0;
            ex_ctrl     <= '0;
        end else if (bubble) begin
            ex_valid    <= 1'b0;
            ex_RegWrite <= 1'b0;
            ex_MemRead  <= 1'b0;
            ex_Rd       <= REG_ZERO;
            ex_A        <= '0;
            ex_B        <= '0;
            ex_ctrl     <= '0;
        end else begin
            ex_valid    <= id_valid;
            ex_RegWrite <= id_RegWrite && id_valid;
            ex_MemRead  <= id_MemRead && id_valid;
            ex_Rd       <= id_Rd;
            ex_A        <= fwdA;
            ex_B        <= fwdB;
            ex_ctrl     <= id_ctrl;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            stallCount <= '0;
        else if (stall_id && (stallCount != 32'hFFFF_FFFF))
            stallCount <= stallCount + 32'd1;
    end

    assign stall_cycles = stallCount;

endmodule

// File: tb/tb_id_ex_stage.sv
// Randomized and directed stimulus for id_ex_stage, checked by a scoreboard
// fed from a reference model of the forwarding/hazard rules.
module tb_id_ex_stage;

    logic        clk;
    logic        reset;
    logic        id_valid;
    logic [4:0]  id_Rn, id_Rm, id_Rd;
    logic        id_uses_Rn, id_uses_Rm;
    logic        id_RegWrite, id_MemRead;
    logic [15:0] id_ctrl;
    logic [63:0] ReadData1, ReadData2, ex_alu_result;
    logic        mem_valid, mem_RegWrite;
    logic [4:0]  mem_Rd;
    logic [63:0] mem_result;
    logic        wb_valid, wb_RegWrite;
    logic [4:0]  wb_Rd;
    logic [63:0] wb_data;
    logic        flush;
    logic        stall_id;
    logic        ex_valid, ex_RegWrite, ex_MemRead;
    logic [4:0]  ex_Rd;
    logic [63:0] ex_A, ex_B;
    logic [15:0] ex_ctrl;
    logic [31:0] stall_cycles;

    typedef struct {
        logic        valid;
        logic [4:0]  rn, rm, rd;
        logic        usesRn, usesRm, regWrite, memRead;
        logic [15:0] ctrl;
        logic [63:0] rd1, rd2, exAlu;
        logic        memValid, memRegWrite;
        logic [4:0]  memRd;
        logic [63:0] memResult;
        logic        wbValid, wbRegWrite;
        logic [4:0]  wbRd;
        logic [63:0] wbData;
        logic        flush;
    } stim_t;

    typedef struct {
        logic        valid, regWrite, memRead;
        logic [4:0]  rd;
        logic [63:0] a, b;
        logic [15:0] ctrl;
        logic [31:0] count;
    } exp_t;

    exp_t  model;
    exp_t  scoreboard[$];
    int    checks = 0;
    int    passes = 0;
    stim_t s;

    id_ex_stage #(.WIDTH(64), .CTRLW(16)) dut (
        .clk(clk), .reset(reset),
        .id_valid(id_valid), .id_Rn(id_Rn), .id_Rm(id_Rm),
        .id_uses_Rn(id_uses_Rn), .id_uses_Rm(id_uses_Rm), .id_Rd(id_Rd),
        .id_RegWrite(id_RegWrite), .id_MemRead(id_MemRead), .id_ctrl(id_ctrl),
        .ReadData1(ReadData1), .ReadData2(ReadData2), .ex_alu_result(ex_alu_result),
        .mem_valid(mem_valid), .mem_RegWrite(mem_RegWrite), .mem_Rd(mem_Rd), .mem_result(mem_result),
        .wb_valid(wb_valid), .wb_RegWrite(wb_RegWrite), .wb_Rd(wb_Rd), .wb_data(wb_data),
        .flush(flush), .stall_id(stall_id),
        .ex_valid(ex_valid), .ex_RegWrite(ex_RegWrite), .ex_MemRead(ex_MemRead),
        .ex_Rd(ex_Rd), .ex_A(ex_A), .ex_B(ex_B), .ex_ctrl(ex_ctrl),
        .stall_cycles(stall_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual === expected) passes++;
        else $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    endtask

    function automatic exp_t bubbleRec(input logic [31:0] count);
        exp_t e;
        e.valid = 0; e.regWrite = 0; e.memRead = 0; e.rd = 5'd31;
        e.a = 0; e.b = 0; e.ctrl = 0; e.count = count;
        return e;
    endfunction

    function automatic stim_t idle();
        stim_t t;
        t.valid = 0; t.rn = 0; t.rm = 0; t.rd = 0;
        t.usesRn = 0; t.usesRm = 0; t.regWrite = 0; t.memRead = 0;
        t.ctrl = 0; t.rd1 = 0; t.rd2 = 0; t.exAlu = 0;
        t.memValid = 0; t.memRegWrite = 0; t.memRd = 0; t.memResult = 0;
        t.wbValid = 0; t.wbRegWrite = 0; t.wbRd = 0; t.wbData = 0;
        t.flush = 0;
        return t;
    endfunction

    function automatic logic [4:0] pickReg();
        case ($urandom_range(0, 3))
            0: return 5'd1;
            1: return 5'd2;
            2: return 5'd3;
            default: return 5'd31;
        endcase
    endfunction

    function automatic stim_t randomStim();
        stim_t t;
        t.valid = ($urandom_range(0, 7) != 0);
        t.rn = pickReg(); t.rm = pickReg(); t.rd = pickReg();
        t.usesRn = 1'($urandom); t.usesRm = 1'($urandom);
        t.regWrite = ($urandom_range(0, 3) != 0);
        t.memRead = ($urandom_range(0, 2) == 0);
        t.ctrl = 16'($urandom);
        t.rd1 = {$urandom, $urandom}; t.rd2 = {$urandom, $urandom};
        t.exAlu = {$urandom, $urandom};
        t.memValid = 1'($urandom); t.memRegWrite = 1'($urandom);
        t.memRd = pickReg(); t.memResult = {$urandom, $urandom};
        t.wbValid = 1'($urandom); t.wbRegWrite = 1'($urandom);
        t.wbRd = pickReg(); t.wbData = {$urandom, $urandom};
        t.flush = ($urandom_range(0, 9) == 0);
        return t;
    endfunction

    // Reference operand: youngest real writer of the register, loads in EX excluded.
    function automatic logic [63:0] refOperand(input logic [4:0] src, input logic uses,
                                               input logic [63:0] rf, input stim_t t);
        if (!uses || src == 5'd31) return rf;
        if (model.valid && model.regWrite && !model.memRead && model.rd == src) return t.exAlu;
        if (t.memValid && t.memRegWrite && t.memRd == src) return t.memResult;
        if (t.wbValid && t.wbRegWrite && t.wbRd == src) return t.wbData;
        return rf;
    endfunction

    // Drive one decode cycle (called at a negedge), check the stall and queue the expected EX state.
    task automatic applyStimulus(input stim_t t);
        logic  expStall;
        exp_t  nxt;
        id_valid = t.valid; id_Rn = t.rn; id_Rm = t.rm; id_Rd = t.rd;
        id_uses_Rn = t.usesRn; id_uses_Rm = t.usesRm;
        id_RegWrite = t.regWrite; id_MemRead = t.memRead; id_ctrl = t.ctrl;
        ReadData1 = t.rd1; ReadData2 = t.rd2; ex_alu_result = t.exAlu;
        mem_valid = t.memValid; mem_RegWrite = t.memRegWrite; mem_Rd = t.memRd; mem_result = t.memResult;
        wb_valid = t.wbValid; wb_RegWrite = t.wbRegWrite; wb_Rd = t.wbRd; wb_data = t.wbData;
        flush = t.flush;
        expStall = t.valid && !t.flush && model.valid && model.memRead && model.regWrite &&
                   model.rd != 5'd31 &&
                   ((t.usesRn && t.rn == model.rd) || (t.usesRm && t.rm == model.rd));
        #1;
        checkOutput("stall_id", {63'd0, stall_id}, {63'd0, expStall});
        if (t.flush || expStall) begin
            nxt = bubbleRec(model.count);
        end else begin
            nxt.valid = t.valid; nxt.regWrite = t.regWrite && t.valid;
            nxt.memRead = t.memRead && t.valid; nxt.rd = t.rd; nxt.ctrl = t.ctrl;
            nxt.a = refOperand(t.rn, t.usesRn, t.rd1, t);
            nxt.b = refOperand(t.rm, t.usesRm, t.rd2, t);
            nxt.count = model.count;
        end
        if (expStall && model.count != 32'hFFFF_FFFF) nxt.count = model.count + 1;
        model = nxt;
        scoreboard.push_back(nxt);
    endtask

    task automatic step(input stim_t t);
        applyStimulus(t);
        @(negedge clk);
    endtask

    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (!reset && scoreboard.size() > 0) begin
                e = scoreboard.pop_front();
                checkOutput("ex_valid", {63'd0, ex_valid}, {63'd0, e.valid});
                checkOutput("ex_RegWrite", {63'd0, ex_RegWrite}, {63'd0, e.regWrite});
                checkOutput("ex_MemRead", {63'd0, ex_MemRead}, {63'd0, e.memRead});
                checkOutput("ex_Rd", {59'd0, ex_Rd}, {59'd0, e.rd});
                checkOutput("ex_A", ex_A, e.a);
                checkOutput("ex_B", ex_B, e.b);
                checkOutput("ex_ctrl", {48'd0, ex_ctrl}, {48'd0, e.ctrl});
                checkOutput("stall_cycles", {32'd0, stall_cycles}, {32'd0, e.count});
            end
        end
    end

    initial begin
        stim_t ld, sub;
        reset = 1'b1;
        model = bubbleRec(0);
        applyInputsIdle();
        #3;
        checkOutput("rst_ex_valid", {63'd0, ex_valid}, 64'd0);
        checkOutput("rst_ex_Rd", {59'd0, ex_Rd}, 64'd31);
        checkOutput("rst_stall_cycles", {32'd0, stall_cycles}, 64'd0);
        checkOutput("rst_stall_id", {63'd0, stall_id}, 64'd0);
        checkOutput("rst_ex_A", ex_A, 64'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 400; i++) step(randomStim());

        ld = idle(); ld.valid = 1; ld.rd = 5'd2; ld.regWrite = 1; ld.memRead = 1;
        sub = idle(); sub.valid = 1; sub.rn = 5'd3; sub.rm = 5'd2; sub.usesRn = 1; sub.usesRm = 1;
        sub.rd = 5'd4; sub.regWrite = 1; sub.rd1 = 64'h11; sub.rd2 = 64'h22;

        // Reset arriving while decode is stalled behind a load.
        step(ld);
        applyStimulus(sub);
        checkOutput("midrst_pre_ex_valid", {63'd0, ex_valid}, 64'd1);
        #2;
        reset = 1'b1;
        scoreboard.delete();
        model = bubbleRec(0);
        #1;
        checkOutput("midrst_stall_id", {63'd0, stall_id}, 64'd0);
        checkOutput("midrst_ex_valid", {63'd0, ex_valid}, 64'd0);
        checkOutput("midrst_ex_Rd", {59'd0, ex_Rd}, 64'd31);
        checkOutput("midrst_stall_cycles", {32'd0, stall_cycles}, 64'd0);
        @(negedge clk);
        reset = 1'b0;

        // Load-use: one bubble, then the load value arrives via MEM.
        step(ld);
        applyStimulus(sub);
        checkOutput("lu_stall", {63'd0, stall_id}, 64'd1);
        @(posedge clk); #1;
        checkOutput("lu_bubble", {63'd0, ex_valid}, 64'd0);
        @(negedge clk);
        s = sub; s.memValid = 1; s.memRegWrite = 1; s.memRd = 5'd2; s.memResult = 64'hABCD;
        applyStimulus(s);
        @(posedge clk); #1;
        checkOutput("lu_ex_B", ex_B, 64'hABCD);
        checkOutput("lu_count", {32'd0, stall_cycles}, 64'd1);
        @(negedge clk);

        // Loads and producers targeting X31 never stall or forward.
        s = ld; s.rd = 5'd31;
        step(s);
        s = idle(); s.valid = 1; s.rn = 5'd31; s.usesRn = 1; s.rd = 5'd5;
        s.memValid = 1; s.memRegWrite = 1; s.memRd = 5'd31; s.memResult = 64'hDEAD;
        s.wbValid = 1; s.wbRegWrite = 1; s.wbRd = 5'd31; s.wbData = 64'hBEEF;
        applyStimulus(s);
        checkOutput("x31_stall", {63'd0, stall_id}, 64'd0);
        @(posedge clk); #1;
        checkOutput("x31_ex_A", ex_A, 64'd0);
        @(negedge clk);

        // Flush beats a simultaneous load-use stall.
        step(ld);
        s = sub; s.flush = 1;
        applyStimulus(s);
        checkOutput("flush_stall", {63'd0, stall_id}, 64'd0);
        @(posedge clk); #1;
        checkOutput("flush_bubble", {63'd0, ex_valid}, 64'd0);
        checkOutput("flush_count", {32'd0, stall_cycles}, 64'd1);
        @(negedge clk);

        // Forwarding priority: EX, then MEM, then WB, then the register file.
        s = idle(); s.valid = 1; s.rd = 5'd1; s.regWrite = 1;
        step(s);
        s = idle(); s.valid = 1; s.rn = 5'd1; s.usesRn = 1; s.rd = 5'd5; s.regWrite = 1;
        s.rd1 = 64'h5; s.exAlu = 64'h10;
        s.memValid = 1; s.memRegWrite = 1; s.memRd = 5'd1; s.memResult = 64'h20;
        s.wbValid = 1; s.wbRegWrite = 1; s.wbRd = 5'd1; s.wbData = 64'h30;
        applyStimulus(s); @(posedge clk); #1; checkOutput("prio_ex", ex_A, 64'h10); @(negedge clk);
        applyStimulus(s); @(posedge clk); #1; checkOutput("prio_mem", ex_A, 64'h20); @(negedge clk);
        s.memValid = 0;
        applyStimulus(s); @(posedge clk); #1; checkOutput("prio_wb", ex_A, 64'h30); @(negedge clk);
        s.wbValid = 0;
        applyStimulus(s); @(posedge clk); #1; checkOutput("prio_rf", ex_A, 64'h5); @(negedge clk);

        // Counter saturation, starting just below the limit.
        force dut.stallCount = 32'hFFFF_FFFD;
        model.count = 32'hFFFF_FFFD;
        #1;
        release dut.stallCount;
        for (int i = 0; i < 4; i++) begin
            step(ld);
            step(sub);
            step(sub);
        end
        checkOutput("sat_count", {32'd0, stall_cycles}, 64'hFFFF_FFFF);

        for (int i = 0; i < 100; i++) step(randomStim());
        applyInputsIdle();
        @(posedge clk); #2;
        checkOutput("sb_drained", 64'(scoreboard.size()), 64'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    task automatic applyInputsIdle();
        stim_t t;
        t = idle();
        id_valid = t.valid; id_Rn = t.rn; id_Rm = t.rm; id_Rd = t.rd;
        id_uses_Rn = 0; id_uses_Rm = 0; id_RegWrite = 0; id_MemRead = 0; id_ctrl = 0;
        ReadData1 = 0; ReadData2 = 0; ex_alu_result = 0;
        mem_valid = 0; mem_RegWrite = 0; mem_Rd = 0; mem_result = 0;
        wb_valid = 0; wb_RegWrite = 0; wb_Rd = 0; wb_data = 0;
        flush = 0;
    endtask

endmodule
